// File: rtl/imem_responder.sv
// Instruction-memory responder: serves fetch reads with one-cycle latency and
// holds the CPU while a byte-serial loader fills the memory.
module imem_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 4096,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           address_imem,
  output logic [31:0]           q_imem,
  output logic                  q_valid,
  output logic                  cpu_hold,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_length,
  input  logic [7:0]            load_byte,
  input  logic                  load_byte_valid,
  output logic                  load_done
);

  typedef enum logic [1:0] {
    S_HOLD,
    S_LOAD,
    S_DONE,
    S_RUN
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state_q;
  logic [31:0]           q_imem_q;
  logic                  q_valid_q;
  logic                  cpu_hold_q;
  logic                  load_done_q;
  logic [ADDR_WIDTH:0]   loaded_count_q;
  logic [ADDR_WIDTH:0]   latched_len_q;
  logic [ADDR_WIDTH-1:0] write_addr_q;
  logic [1:0]            byte_idx_q;
  logic [31:0]           asm_q;

  logic [31:0]           mem [DEPTH];

  logic [31:0]           asm_d;
  logic [ADDR_WIDTH:0]   len_clamp_d;
  logic [ADDR_WIDTH:0]   count_inc_d;
  logic                  mem_we;
  logic                  start_ok;
  logic                  rd_hit;

  // Datapath helpers: byte assembly, length clamp, write enable, read hit.
  always_comb begin
    asm_d       = {asm_q[23:0], load_byte};
    len_clamp_d = (load_length > DEPTH_W) ? DEPTH_W : load_length;
    count_inc_d = loaded_count_q + (ADDR_WIDTH + 1)'(1);
    mem_we      = (state_q == S_LOAD) && load_byte_valid && (byte_idx_q == 2'd3);
    start_ok    = load_start && (load_length != '0);
    rd_hit      = (address_imem[31:ADDR_WIDTH] == '0) &&
                  ({1'b0, address_imem[ADDR_WIDTH-1:0]} < loaded_count_q);
  end

  // Memory write port; contents deliberately survive reset (masked by loaded_count).
  always_ff @(posedge clock) begin
    if (mem_we) mem[write_addr_q] <= asm_d;
  end

  // Loader/serving FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_HOLD;
      q_imem_q       <= NOP_WORD;
      q_valid_q      <= 1'b0;
      cpu_hold_q     <= 1'b1;
      load_done_q    <= 1'b0;
      loaded_count_q <= '0;
      latched_len_q  <= '0;
      write_addr_q   <= '0;
      byte_idx_q     <= '0;
      asm_q          <= '0;
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        S_HOLD: begin
          q_imem_q   <= NOP_WORD;
          q_valid_q  <= 1'b0;
          cpu_hold_q <= 1'b1;
          if (start_ok) begin
            state_q        <= S_LOAD;
            latched_len_q  <= len_clamp_d;
            write_addr_q   <= '0;
            byte_idx_q     <= '0;
            loaded_count_q <= '0;
            asm_q          <= '0;
          end
        end
        S_LOAD: begin
          q_imem_q   <= NOP_WORD;
          q_valid_q  <= 1'b0;
          cpu_hold_q <= 1'b1;
          if (load_byte_valid) begin
            asm_q      <= asm_d;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              write_addr_q   <= write_addr_q + ADDR_WIDTH'(1);
              loaded_count_q <= count_inc_d;
              if (count_inc_d == latched_len_q) begin
                state_q     <= S_DONE;
                load_done_q <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          // The first RUN cycle must already carry a valid result, so the
          // read for the current address is sampled on the DONE->RUN edge.
          state_q    <= S_RUN;
          cpu_hold_q <= 1'b0;
          q_valid_q  <= 1'b1;
          q_imem_q   <= rd_hit ? mem[address_imem[ADDR_WIDTH-1:0]] : NOP_WORD;
        end
        S_RUN: begin
          if (start_ok) begin
            state_q        <= S_LOAD;
            cpu_hold_q     <= 1'b1;
            q_valid_q      <= 1'b0;
            q_imem_q       <= NOP_WORD;
            latched_len_q  <= len_clamp_d;
            write_addr_q   <= '0;
            byte_idx_q     <= '0;
            loaded_count_q <= '0;
            asm_q          <= '0;
          end else begin
            cpu_hold_q <= 1'b0;
            q_valid_q  <= 1'b1;
            q_imem_q   <= rd_hit ? mem[address_imem[ADDR_WIDTH-1:0]] : NOP_WORD;
          end
        end
        default: state_q <= S_HOLD;
      endcase
    end
  end

  assign q_imem    = q_imem_q;
  assign q_valid   = q_valid_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder.
module tb_imem_responder;

  localparam int unsigned AW = 12;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address_imem;
  logic [31:0] q_imem;
  logic        q_valid;
  logic        cpu_hold;
  logic        load_start;
  logic [AW:0] load_length;
  logic [7:0]  load_byte;
  logic        load_byte_valid;
  logic        load_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_q;
  } rd_vec_t;

  rd_vec_t vecs [8];

  always #5 clock = ~clock;

  imem_responder #(.ADDR_WIDTH(AW), .DEPTH(4096), .NOP_WORD(32'h0)) dut (
    .clock          (clock),
    .reset          (reset),
    .address_imem   (address_imem),
    .q_imem         (q_imem),
    .q_valid        (q_valid),
    .cpu_hold       (cpu_hold),
    .load_start     (load_start),
    .load_length    (load_length),
    .load_byte      (load_byte),
    .load_byte_valid(load_byte_valid),
    .load_done      (load_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_byte       = b;
    load_byte_valid = 1'b1;
    tick();
    load_byte_valid = 1'b0;
  endtask

  task automatic chk_hold(input string name);
    chk({name, ".cpu_hold"}, 32'(cpu_hold), 32'd1);
    chk({name, ".q_valid"}, 32'(q_valid), 32'd0);
    chk({name, ".q_imem"}, q_imem, 32'h0);
    chk({name, ".load_done"}, 32'(load_done), 32'd0);
  endtask

  task automatic start_load(input logic [AW:0] len);
    load_start  = 1'b1;
    load_length = len;
    tick();
    load_start  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h1234_5678};
    vecs[1] = '{32'h0000_0001, 32'h9ABC_DEF0};
    vecs[2] = '{32'h0000_0002, 32'h0000_0000};
    vecs[3] = '{32'h0000_1000, 32'h0000_0000};
    vecs[4] = '{32'h0000_0001, 32'h9ABC_DEF0};
    vecs[5] = '{32'h0000_0000, 32'h1234_5678};
    vecs[6] = '{32'h0000_0001, 32'h9ABC_DEF0};
    vecs[7] = '{32'h0000_0000, 32'h1234_5678};

    reset           = 1'b1;
    address_imem    = '0;
    load_start      = 1'b0;
    load_length     = '0;
    load_byte       = '0;
    load_byte_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      tick();
      chk_hold("idle");
    end

    // Two-word load with one idle gap between the words.
    start_load(13'd2);
    chk_hold("after_start");
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    tick();
    send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE);
    chk("pre_done.load_done", 32'(load_done), 32'd0);
    chk("pre_done.cpu_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'hF0);
    chk("done.load_done", 32'(load_done), 32'd1);
    chk("done.cpu_hold", 32'(cpu_hold), 32'd1);
    chk("done.q_valid", 32'(q_valid), 32'd0);
    tick();
    chk("run0.load_done", 32'(load_done), 32'd0);
    chk("run0.cpu_hold", 32'(cpu_hold), 32'd0);
    chk("run0.q_valid", 32'(q_valid), 32'd1);
    chk("run0.q_imem", q_imem, 32'h1234_5678);

    // Table of reads in RUN, one new address per cycle.
    for (int i = 0; i < 8; i++) begin
      address_imem = vecs[i].addr;
      tick();
      chk($sformatf("rd%0d.q_imem", i), q_imem, vecs[i].exp_q);
      chk($sformatf("rd%0d.q_valid", i), 32'(q_valid), 32'd1);
      chk($sformatf("rd%0d.cpu_hold", i), 32'(cpu_hold), 32'd0);
    end

    // Reload requested from RUN, abandoned mid-word by reset.
    address_imem = 32'h0;
    start_load(13'd1);
    chk_hold("reload_start");
    send_byte(8'h11); send_byte(8'h22);
    chk_hold("reload_partial");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_hold("reset_midload");

    // Zero-length start and stray bytes in HOLD are ignored.
    start_load(13'd0);
    chk_hold("zero_len");
    for (int i = 0; i < 6; i++) begin
      send_byte(8'(i + 1));
      chk_hold($sformatf("stray%0d", i));
    end
    tick();
    chk_hold("stray_end");

    // One-word reload; a start pulse in LOAD must not restart the word.
    start_load(13'd1);
    send_byte(8'hCA); send_byte(8'hFE);
    load_start      = 1'b1;
    load_length     = 13'd3;
    load_byte       = 8'hBA;
    load_byte_valid = 1'b1;
    tick();
    load_start      = 1'b0;
    load_byte_valid = 1'b0;
    chk("load_ignore_start.load_done", 32'(load_done), 32'd0);
    send_byte(8'hBE);
    chk("reload.load_done", 32'(load_done), 32'd1);
    tick();
    chk("reload_run.cpu_hold", 32'(cpu_hold), 32'd0);
    chk("reload_run.load_done", 32'(load_done), 32'd0);
    address_imem = 32'h1;
    tick();
    chk("masked.q_imem", q_imem, 32'h0);
    chk("masked.q_valid", 32'(q_valid), 32'd1);
    address_imem = 32'h0;
    tick();
    chk("cafe.q_imem", q_imem, 32'hCAFE_BABE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
